// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Holds the FSM state encoding, the result record and the slice-index width function.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic lg;
        logic eq;
        logic ls;
    } cmp_res_t;

    // Keep the index at least one bit wide so NSLICE = 1 still gets a legal vector.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/slice_cmp.sv
// Combinational unsigned compare of one SLICE-bit slice.
// Signed compares are handled upstream by flipping the operand sign bits.
module slice_cmp #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, SLICE bits per cycle, MSB slice first.
// Optional macro SEQ_CMP_EARLY_EXIT_EN ends RUN on the first differing slice.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready = 1
//   RUN   | comparing one slice per edge, from the top slice down
//   DONE  | result held on lg/eq/ls until the consumer takes it
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lg,
    output logic             eq,
    output logic             ls
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("seq_magnitude_comparator: WIDTH (%0d) must be a multiple of SLICE (%0d)",
               WIDTH, SLICE);
    end

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IDX_W-1:0] idx;
    logic             found;
    logic             gt_r;
    logic             lt_r;
    logic             out_valid_r;
    cmp_res_t         res;

    logic [NSLICE-1:0][SLICE-1:0] a_sl;
    logic [NSLICE-1:0][SLICE-1:0] b_sl;
    logic                         sl_gt;
    logic                         sl_lt;
    logic                         gt_next;
    logic                         lt_next;
    logic                         last_slice;

    assign a_sl = a_r;
    assign b_sl = b_r;

    slice_cmp #(
        .SLICE (SLICE)
    ) u_slice_cmp (
        .a  (a_sl[idx]),
        .b  (b_sl[idx]),
        .gt (sl_gt),
        .lt (sl_lt)
    );

    // Once a slice has differed, the verdict is frozen; lower slices are don't-care.
    always_comb begin
        gt_next = found ? gt_r : sl_gt;
        lt_next = found ? lt_r : sl_lt;
`ifdef SEQ_CMP_EARLY_EXIT_EN
        last_slice = (idx == '0) || gt_next || lt_next;
`else
        last_slice = (idx == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            idx         <= IDX_TOP;
            found       <= 1'b0;
            gt_r        <= 1'b0;
            lt_r        <= 1'b0;
            out_valid_r <= 1'b0;
            res         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a ^ (sig ? SIGN_BIT : '0);
                        b_r   <= b ^ (sig ? SIGN_BIT : '0);
                        idx   <= IDX_TOP;
                        found <= 1'b0;
                        gt_r  <= 1'b0;
                        lt_r  <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    gt_r  <= gt_next;
                    lt_r  <= lt_next;
                    found <= gt_next | lt_next;
                    if (idx != '0) begin
                        idx <= idx - IDX_W'(1);
                    end
                    if (last_slice) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        res.lg      <= gt_next;
                        res.eq      <= ~(gt_next | lt_next);
                        res.ls      <= lt_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        res         <= '0;
                        idx         <= IDX_TOP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_r;
    assign lg        = res.lg;
    assign eq        = res.eq;
    assign ls        = res.ls;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator: W16/S4, W4/S1 and W8/S4 instances.
// Expected latency follows SEQ_CMP_EARLY_EXIT_EN when it is defined.
module tb_seq_magnitude_comparator;

`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [2:0] in_valid_v;
    logic [2:0] sig_v;
    logic [2:0] out_ready_v;
    logic [15:0] a16, b16;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    wire  [2:0] in_ready_w;
    wire  [2:0] out_valid_w;
    wire  [2:0] lg_w;
    wire  [2:0] eq_w;
    wire  [2:0] ls_w;

    int n_pass  = 0;
    int n_total = 0;

    seq_magnitude_comparator #(.WIDTH(16), .SLICE(4)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
        .a(a16), .b(b16), .sig(sig_v[0]), .out_valid(out_valid_w[0]),
        .out_ready(out_ready_v[0]), .lg(lg_w[0]), .eq(eq_w[0]), .ls(ls_w[0]));

    seq_magnitude_comparator #(.WIDTH(4), .SLICE(1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
        .a(a4), .b(b4), .sig(sig_v[1]), .out_valid(out_valid_w[1]),
        .out_ready(out_ready_v[1]), .lg(lg_w[1]), .eq(eq_w[1]), .ls(ls_w[1]));

    seq_magnitude_comparator #(.WIDTH(8), .SLICE(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
        .a(a8), .b(b8), .sig(sig_v[2]), .out_valid(out_valid_w[2]),
        .out_ready(out_ready_v[2]), .lg(lg_w[2]), .eq(eq_w[2]), .ls(ls_w[2]));

    function automatic int width_of(input int inst);
        return (inst == 0) ? 16 : (inst == 1) ? 4 : 8;
    endfunction

    function automatic int slice_of(input int inst);
        return (inst == 1) ? 1 : 4;
    endfunction

    // Reference: interpret operands as plain integers and compare them.
    function automatic logic [2:0] ref_cmp(input int w, input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
        longint mask = (longint'(1) << w) - 1;
        longint av = longint'(a) & mask;
        longint bv = longint'(b) & mask;
        if (s && av[w-1]) av -= (longint'(1) << w);
        if (s && bv[w-1]) bv -= (longint'(1) << w);
        return {av > bv, av == bv, av < bv};
    endfunction

    // Reference latency: NSLICE, or with early exit the 1-based position of the top differing slice.
    function automatic int ref_lat(input int w, input int sl, input logic [15:0] a,
                                   input logic [15:0] b);
        int nsl = w / sl;
        logic [15:0] diff = a ^ b;
        if (!EARLY) return nsl;
        for (int i = w - 1; i >= 0; i--) begin
            if (diff[i]) return nsl - i / sl;
        end
        return nsl;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input int inst, input logic [15:0] a, input logic [15:0] b, input logic s);
        case (inst)
            0: begin a16 = a; b16 = b; end
            1: begin a4 = a[3:0]; b4 = b[3:0]; end
            default: begin a8 = a[7:0]; b8 = b[7:0]; end
        endcase
        sig_v[inst] = s;
    endtask

    function automatic logic [3:0] outs(input int inst);
        return {out_valid_w[inst], lg_w[inst], eq_w[inst], ls_w[inst]};
    endfunction

    task automatic start_op(input int inst, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input string name);
        int t = 0;
        @(negedge clk);
        while (!in_ready_w[inst] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check({name, "_in_ready_timeout"}, 0, 1);
        drive(inst, a, b, s);
        in_valid_v[inst] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[inst] = 1'b0;
        check({name, "_in_ready_busy"}, in_ready_w[inst], 0);
    endtask

    task automatic wait_result(input int inst, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid_w[inst] && n < 40);
    endtask

    task automatic finish_op(input int inst, input logic [2:0] e, input bit rnd, input string name);
        int t = 0;
        forever begin
            @(negedge clk);
            out_ready_v[inst] = (rnd && t < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
            if (out_ready_v[inst]) break;
            check({name, "_hold"}, outs(inst), {1'b1, e});
            t++;
        end
        out_ready_v[inst] = 1'b0;
        check({name, "_release"}, {out_valid_w[inst], in_ready_w[inst]}, 2'b01);
    endtask

    task automatic run_op(input int inst, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [2:0] e, input int e_lat, input bit rnd,
                          input string name);
        int n;
        start_op(inst, a, b, s, name);
        wait_result(inst, n);
        check({name, "_latency"}, n, e_lat);
        check({name, "_flags"}, outs(inst), {1'b1, e});
        check({name, "_onehot"}, $countones({lg_w[inst], eq_w[inst], ls_w[inst]}), 1);
        finish_op(inst, e, rnd, name);
    endtask

    typedef struct {
        int          inst;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [2:0]  e;       // {lg, eq, ls}
        int          lat_base;
        int          lat_early;
        string       name;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n;
        logic [15:0] ra, rb;
        logic rs;

        tbl[0] = '{0, 16'h1234, 16'h1234, 1'b0, 3'b010, 4, 4, "equal_1234"};
        tbl[1] = '{0, 16'h8000, 16'h7FFF, 1'b0, 3'b100, 4, 1, "unsigned_msb"};
        tbl[2] = '{0, 16'h8000, 16'h7FFF, 1'b1, 3'b001, 4, 1, "signed_msb"};
        tbl[3] = '{0, 16'h1235, 16'h1234, 1'b0, 3'b100, 4, 4, "low_slice"};
        tbl[4] = '{0, 16'hFFFF, 16'h0001, 1'b1, 3'b001, 4, 1, "signed_neg1"};
        tbl[5] = '{1, 16'h0008, 16'h0007, 1'b1, 3'b001, 4, 1, "w4_signed"};
        tbl[6] = '{1, 16'h0002, 16'h0003, 1'b0, 3'b001, 4, 4, "w4_low_bit"};
        tbl[7] = '{2, 16'h0080, 16'h0080, 1'b1, 3'b010, 2, 2, "w8_equal"};
        tbl[8] = '{2, 16'h007F, 16'h0080, 1'b1, 3'b100, 2, 1, "w8_signed"};
        tbl[9] = '{2, 16'h0013, 16'h0012, 1'b0, 3'b100, 2, 2, "w8_low_slice"};

        rst_n       = 1'b0;
        in_valid_v  = '0;
        sig_v       = '0;
        out_ready_v = '0;
        a16 = '0; b16 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(0), 4'b0000);
        check("reset_in_ready", in_ready_w, 3'b111);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_op(tbl[i].inst, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].e,
                   EARLY ? tbl[i].lat_early : tbl[i].lat_base, 1'b0, tbl[i].name);
        end

        // Backpressure: result must hold while new operands are waved at the input.
        start_op(0, 16'h0005, 16'h0003, 1'b0, "bp");
        wait_result(0, n);
        check("bp_latency", n, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            out_ready_v[0] = 1'b0;
            in_valid_v[0]  = ~in_valid_v[0];
            drive(0, 16'(i), 16'hFFFF, 1'b1);
            @(posedge clk);
            #1;
            check("bp_stable", outs(0), 4'b1100);
            check("bp_in_ready", in_ready_w[0], 0);
        end
        @(negedge clk);
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[0] = 1'b0;
        check("bp_release", {out_valid_w[0], in_ready_w[0]}, 2'b01);
        repeat (6) @(posedge clk);
        #1;
        check("bp_no_phantom", outs(0), 4'b0000);

        // Reset in the middle of an operation.
        start_op(0, 16'h8000, 16'h7FFF, 1'b0, "rst_mid");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", outs(0), 4'b0000);
        check("rst_mid_in_ready", in_ready_w[0], 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rst_no_stale", outs(0), 4'b0000);
        run_op(0, 16'h0001, 16'h0002, 1'b0, 3'b001, ref_lat(16, 4, 16'h0001, 16'h0002), 1'b0,
               "after_rst");

        // out_ready while idle must not create a result.
        @(negedge clk);
        out_ready_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready_v[0] = 1'b0;
        check("idle_out_ready", outs(0), 4'b0000);

        // Exhaustive W4/S1 sweep.
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    ra = 16'(x);
                    rb = 16'(y);
                    run_op(1, ra, rb, 1'(s), ref_cmp(4, ra, rb, 1'(s)), ref_lat(4, 1, ra, rb),
                           1'b1, "sweep_w4");
                end
            end
        end

        // W8/S4: random pairs, with equal pairs mixed in.
        for (int i = 0; i < 1500; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = (i % 7 == 0) ? ra : 16'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            run_op(2, ra, rb, rs, ref_cmp(8, ra, rb, rs), ref_lat(8, 4, ra, rb), 1'b1, "sweep_w8");
        end

        // W16/S4: random pairs through the wide instance.
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = (i % 5 == 0) ? (ra ^ (16'(1) << $urandom_range(0, 15))) : 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            run_op(0, ra, rb, rs, ref_cmp(16, ra, rb, rs), ref_lat(16, 4, ra, rb), 1'b1,
                   "rand_w16");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
